// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the instruction/data memory arbiter.
//   - FSM state encodings (IDLE, ACCESS, WAIT, RESP)
//   - owner encodings (OWN_IF = fetch port, OWN_DM = data port)
//   - cnt_width(): width of the read-latency wait counter
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t WAIT   = 2'd2;
  localparam state_t RESP   = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // The counter is loaded with RD_LATENCY-1, so clog2(RD_LATENCY) bits are
  // enough; a latency of 1 still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int rd_latency);
    int w;
    w = $clog2(rd_latency);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if
// Bundles the fetch port, data port and RAM-side signals of the arbiter.
//   Fetch port : if_req, if_addr -> if_rdata, if_ack
//   Data port  : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_ack
//   RAM side   : mem_ce, mem_we, mem_addr, mem_wdata <- mem_rdata
// Modports:
//   slave  - the arbiter's view (takes requests, drives the RAM)
//   master - the surroundings' view (CPU ports plus the RAM read data)
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack,
           mem_ce, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
           mem_ce, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2
// Combinational two-way round-robin pick.
//   req[0]    : fetch port request  (OWN_IF)
//   req[1]    : data port request   (OWN_DM)
//   last      : owner of the previous grant
//   gnt_valid : at least one request is pending
//   gnt_id    : chosen owner
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // A lone requester always wins; on a tie the port that did not win last
  // time gets the grant, which makes dual traffic strictly alternate.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = OWN_IF;
    case (req)
      2'b01:   gnt_id = OWN_IF;
      2'b10:   gnt_id = OWN_DM;
      2'b11:   gnt_id = ~last;
      default: gnt_id = OWN_IF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous RAM between the CPU fetch port and the
// data port. One transaction at a time: IDLE -> ACCESS -> (WAIT) -> RESP.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_arb_if.slave: fetch port, data port and RAM control/data
// All outputs are registered. Address/data are latched at grant time, so a
// requester changing them (or dropping req) mid-transaction has no effect.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  mem_arb_if.slave   bus
);

  localparam int CNT_W = cnt_width(RD_LATENCY);

  state_t            state;
  logic              owner;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;

  logic              gnt_valid;
  logic              gnt_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  rr_arbiter2 u_rr (
    .req       ({bus.dm_req, bus.if_req}),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Request fields of whichever port the round-robin picked; only the data
  // port can write, so fetch grants always present a read with zero data.
  always_comb begin
    sel_addr  = bus.if_addr;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (gnt_id == OWN_DM) begin
      sel_addr  = bus.dm_addr;
      sel_wdata = bus.dm_wdata;
      sel_we    = bus.dm_we;
    end
  end

  // Transaction FSM plus every registered output. mem_ce/mem_we are only
  // high during ACCESS; mem_addr/mem_wdata keep their last value otherwise.
  // Acks are set on entry to RESP and cleared on leaving it, giving a
  // one-cycle pulse. Arbitration only happens in IDLE, so a port acked in
  // RESP always gets a chance to drop req before it can be granted again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      last_grant    <= OWN_DM;
      cnt           <= '0;
      bus.mem_ce    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner         <= gnt_id;
            last_grant    <= gnt_id;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_we    <= sel_we;
            bus.mem_ce    <= 1'b1;
            state         <= ACCESS;
          end
        end

        ACCESS: begin
          bus.mem_ce <= 1'b0;
          bus.mem_we <= 1'b0;
          if (bus.mem_we) begin
            if (owner == OWN_DM) bus.dm_ack <= 1'b1;
            else                 bus.if_ack <= 1'b1;
            state <= RESP;
          end else begin
            cnt   <= CNT_W'(RD_LATENCY - 1);
            state <= WAIT;
          end
        end

        WAIT: begin
          if (cnt == '0) begin
            if (owner == OWN_DM) begin
              bus.dm_rdata <= bus.mem_rdata;
              bus.dm_ack   <= 1'b1;
            end else begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ack   <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RESP: begin
          bus.if_ack <= 1'b0;
          bus.dm_ack <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. dut1 runs with RD_LATENCY=1 against a
// small RAM model; dut3 runs with RD_LATENCY=3 against a pipelined read model.
// Expected acks on dut1 are queued when requests are issued and checked by a
// monitor when the acks appear.
module tb_mem_arbiter;

  typedef struct {
    bit          port;
    bit          is_wr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  exp_t        sb[$];
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;

  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // RAM model for dut1: read data valid one edge after the ACCESS cycle and
  // replaced by garbage afterwards, so late or early capture is visible.
  logic [31:0] ram1 [256];
  logic [31:0] rd1 = '0;

  initial begin
    for (int i = 0; i < 256; i++) ram1[i] = 32'hA500_0000 | i;
    ram1[8'h10] = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (bus1.mem_ce && bus1.mem_we) ram1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    rd1 <= (bus1.mem_ce && !bus1.mem_we) ? ram1[bus1.mem_addr[7:0]] : 32'hBAD0_BAD1;
  end
  assign bus1.mem_rdata = rd1;

  // Three-stage read pipe for dut3: data valid three edges after ACCESS.
  logic [31:0] pipe3 [3];
  initial for (int i = 0; i < 3; i++) pipe3[i] = '0;

  always @(posedge clk) begin
    pipe3[0] <= (bus3.mem_ce && !bus3.mem_we) ? (32'h3C00_0000 | bus3.mem_addr) : 32'hBAD0_BAD3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.mem_rdata = pipe3[2];

  // Scoreboard monitor for dut1: every ack pops one expected transaction.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
    end else if (bus1.if_ack || bus1.dm_ack) begin
      tests_run++;
      if (bus1.if_ack && bus1.dm_ack) begin
        tests_failed++;
        $display("[TB] FAIL sb_dual_ack: if_ack=%b dm_ack=%b, required one ack", bus1.if_ack, bus1.dm_ack);
      end else if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL sb_unexpected_ack: if_ack=%b dm_ack=%b, required no ack", bus1.if_ack, bus1.dm_ack);
      end else begin
        e = sb.pop_front();
        if (bus1.dm_ack !== e.port) begin
          tests_failed++;
          $display("[TB] FAIL sb_port: ack on port %0d, required port %0d", bus1.dm_ack, e.port);
        end else begin
          if (!e.is_wr) begin
            if (e.port) exp_dm_rdata = e.data;
            else        exp_if_rdata = e.data;
          end
          tests_run++;
          if (bus1.if_rdata !== exp_if_rdata || bus1.dm_rdata !== exp_dm_rdata) begin
            tests_failed++;
            $display("[TB] FAIL sb_rdata: if_rdata=%h dm_rdata=%h, required %h %h",
                     bus1.if_rdata, bus1.dm_rdata, exp_if_rdata, exp_dm_rdata);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for an ack on dut1 (port 0 = fetch, 1 = data) for at most maxc cycles.
  task automatic wait_ack1(input bit port, input int maxc, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < maxc) begin
      tick();
      n++;
      if (port ? bus1.dm_ack : bus1.if_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [131:0] outs;
    int  n;
    bit  ok;
    rst            = 1'b1;
    bus1.if_req    = 1'b1;
    bus1.if_addr   = 32'h10;
    bus1.dm_req    = 1'b1;
    bus1.dm_we     = 1'b1;
    bus1.dm_addr   = 32'h20;
    bus1.dm_wdata  = 32'h55;
    bus3.if_req    = 1'b0;
    bus3.if_addr   = '0;
    bus3.dm_req    = 1'b0;
    bus3.dm_we     = 1'b0;
    bus3.dm_addr   = '0;
    bus3.dm_wdata  = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      outs = {bus1.mem_ce, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata,
              bus1.if_ack, bus1.dm_ack, bus1.if_rdata, bus1.dm_rdata};
      tests_run++;
      if (outs !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs: outputs=%h, required 0", outs);
      end
    end
    rst = 1'b0;
    sb.push_back('{port: 1'b0, is_wr: 1'b0, data: 32'hDEAD_BEEF});
    tick();
    tests_run++;
    if (bus1.mem_ce !== 1'b1 || bus1.mem_we !== 1'b0 || bus1.mem_addr !== 32'h10) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_grant: ce=%b we=%b addr=%h, required 1 0 00000010",
               bus1.mem_ce, bus1.mem_we, bus1.mem_addr);
    end
    bus1.dm_req = 1'b0;
    bus1.dm_we  = 1'b0;
    wait_ack1(1'b0, 10, n, ok);
    tests_run++;
    if (!ok || n != 2) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_ack: ack=%b after %0d cycles, required 1 after 2", ok, n);
    end
    bus1.if_req = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    bus1.if_addr = 32'h10;
    bus1.if_req  = 1'b1;
    sb.push_back('{port: 1'b0, is_wr: 1'b0, data: 32'hDEAD_BEEF});
    tick();
    tests_run++;
    if (bus1.mem_ce !== 1'b1 || bus1.mem_addr !== 32'h10) begin
      tests_failed++;
      $display("[TB] FAIL read_access: ce=%b addr=%h, required 1 00000010", bus1.mem_ce, bus1.mem_addr);
    end
    tick();
    tests_run++;
    if (bus1.if_ack !== 1'b0 || bus1.mem_ce !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_wait: if_ack=%b ce=%b, required 0 0", bus1.if_ack, bus1.mem_ce);
    end
    tick();
    tests_run++;
    if (bus1.if_ack !== 1'b1 || bus1.dm_ack !== 1'b0 || bus1.if_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("[TB] FAIL read_ack: if_ack=%b dm_ack=%b if_rdata=%h, required 1 0 deadbeef",
               bus1.if_ack, bus1.dm_ack, bus1.if_rdata);
    end
    bus1.if_req = 1'b0;
    tick();
    tests_run++;
    if (bus1.if_ack !== 1'b0 || bus1.if_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("[TB] FAIL read_hold: if_ack=%b if_rdata=%h, required 0 deadbeef", bus1.if_ack, bus1.if_rdata);
    end
  endtask

  task automatic test_write_read();
    int n;
    bit ok;
    bus1.dm_we    = 1'b1;
    bus1.dm_addr  = 32'h40;
    bus1.dm_wdata = 32'h1234_5678;
    bus1.dm_req   = 1'b1;
    sb.push_back('{port: 1'b1, is_wr: 1'b1, data: 32'h0});
    tick();
    tests_run++;
    if (bus1.mem_ce !== 1'b1 || bus1.mem_we !== 1'b1 || bus1.mem_addr !== 32'h40 ||
        bus1.mem_wdata !== 32'h1234_5678) begin
      tests_failed++;
      $display("[TB] FAIL write_access: ce=%b we=%b addr=%h wdata=%h, required 1 1 00000040 12345678",
               bus1.mem_ce, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata);
    end
    // Requester misbehaves after grant: the latched transaction must finish.
    bus1.dm_req   = 1'b0;
    bus1.dm_wdata = 32'hFFFF_FFFF;
    bus1.dm_addr  = 32'h44;
    tick();
    tests_run++;
    if (bus1.dm_ack !== 1'b1 || bus1.if_ack !== 1'b0 || bus1.mem_ce !== 1'b0 || bus1.mem_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_ack: dm_ack=%b if_ack=%b ce=%b we=%b, required 1 0 0 0",
               bus1.dm_ack, bus1.if_ack, bus1.mem_ce, bus1.mem_we);
    end
    tick();
    bus1.dm_we   = 1'b0;
    bus1.dm_addr = 32'h40;
    bus1.dm_req  = 1'b1;
    sb.push_back('{port: 1'b1, is_wr: 1'b0, data: 32'h1234_5678});
    wait_ack1(1'b1, 10, n, ok);
    tests_run++;
    if (!ok || n != 3 || bus1.dm_rdata !== 32'h1234_5678) begin
      tests_failed++;
      $display("[TB] FAIL write_readback: ack=%b cycles=%0d dm_rdata=%h, required 1 3 12345678",
               ok, n, bus1.dm_rdata);
    end
    bus1.dm_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int if_left = 3;
    int dm_left = 3;
    int k_if    = 0;
    int k_dm    = 0;
    int acks    = 0;
    int cyc     = 0;
    bit exp_owner = 1'b0;
    bus1.if_addr = 32'h80;
    bus1.dm_addr = 32'h84;
    bus1.dm_we   = 1'b0;
    sb.push_back('{port: 1'b0, is_wr: 1'b0, data: 32'hA500_0080});
    sb.push_back('{port: 1'b1, is_wr: 1'b0, data: 32'hA500_0084});
    bus1.if_req = 1'b1;
    bus1.dm_req = 1'b1;
    while (acks < 6 && cyc < 100) begin
      tick();
      cyc++;
      if (bus1.if_ack || bus1.dm_ack) begin
        tests_run++;
        if (bus1.dm_ack !== exp_owner || (bus1.if_ack && bus1.dm_ack)) begin
          tests_failed++;
          $display("[TB] FAIL rr_order: ack %0d if_ack=%b dm_ack=%b, required owner %0d",
                   acks, bus1.if_ack, bus1.dm_ack, exp_owner);
        end
        acks++;
        exp_owner = ~exp_owner;
        if (bus1.if_ack) begin
          if_left--;
          if (if_left == 0) bus1.if_req = 1'b0;
          else begin
            k_if++;
            bus1.if_addr = 32'h80 + 8 * k_if;
            sb.push_back('{port: 1'b0, is_wr: 1'b0, data: 32'hA500_0000 | bus1.if_addr});
          end
        end
        if (bus1.dm_ack) begin
          dm_left--;
          if (dm_left == 0) bus1.dm_req = 1'b0;
          else begin
            k_dm++;
            bus1.dm_addr = 32'h84 + 8 * k_dm;
            sb.push_back('{port: 1'b1, is_wr: 1'b0, data: 32'hA500_0000 | bus1.dm_addr});
          end
        end
      end
    end
    tests_run++;
    if (acks != 6) begin
      tests_failed++;
      $display("[TB] FAIL rr_timeout: %0d acks in %0d cycles, required 6", acks, cyc);
    end
    bus1.if_req = 1'b0;
    bus1.dm_req = 1'b0;
    tick();
  endtask

  task automatic test_latency3();
    int n      = 0;
    int ce_cnt = 0;
    bus3.if_addr = 32'h20;
    bus3.if_req  = 1'b1;
    while (n < 10) begin
      tick();
      n++;
      if (bus3.mem_ce) ce_cnt++;
      if (bus3.if_ack) break;
    end
    tests_run++;
    if (bus3.if_ack !== 1'b1 || n != 5) begin
      tests_failed++;
      $display("[TB] FAIL lat3_ack_time: if_ack=%b after %0d cycles, required 1 after 5", bus3.if_ack, n);
    end
    tests_run++;
    if (bus3.if_rdata !== 32'h3C00_0020 || bus3.dm_ack !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lat3_rdata: if_rdata=%h dm_ack=%b, required 3c000020 0", bus3.if_rdata, bus3.dm_ack);
    end
    tests_run++;
    if (ce_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL lat3_ce_cycles: mem_ce high %0d cycles, required 1", ce_cnt);
    end
    bus3.if_req = 1'b0;
    tick();
    tests_run++;
    if (bus3.if_ack !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lat3_pulse: if_ack=%b, required 0", bus3.if_ack);
    end
  endtask

  task automatic test_reset_mid();
    logic [131:0] outs;
    int n;
    bit ok;
    bus1.if_addr = 32'h14;
    bus1.if_req  = 1'b1;
    sb.push_back('{port: 1'b0, is_wr: 1'b0, data: 32'hA500_0014});
    tick();
    tick();
    rst         = 1'b1;
    bus1.if_req = 1'b0;
    tick();
    outs = {bus1.mem_ce, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata,
            bus1.if_ack, bus1.dm_ack, bus1.if_rdata, bus1.dm_rdata};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_outputs: outputs=%h, required 0", outs);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (bus1.if_ack !== 1'b0 || bus1.mem_ce !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_noack: if_ack=%b ce=%b, required 0 0", bus1.if_ack, bus1.mem_ce);
    end
    bus1.if_addr = 32'h14;
    bus1.if_req  = 1'b1;
    sb.push_back('{port: 1'b0, is_wr: 1'b0, data: 32'hA500_0014});
    wait_ack1(1'b0, 10, n, ok);
    tests_run++;
    if (!ok || n != 3 || bus1.if_rdata !== 32'hA500_0014) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_reissue: ack=%b cycles=%0d if_rdata=%h, required 1 3 a5000014",
               ok, n, bus1.if_rdata);
    end
    bus1.if_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_latency3();
    test_reset_mid();
    tick();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL sb_leftover: %0d expected acks never seen, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
